ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Sequences the single byte-wide RAM/IO port of the RV32I core.
- Shares the port between two requesters: instruction fetch (IF) and load/store (MEM).
- Serialises 1/2/4-byte transfers into byte cycles, assembles and sign-extends read data, and throttles UART writes on io_buffer_full.
- Sits between the IF/MEM stages and the chip-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rdy  in  1  global ready; low freezes all state.
- ram_din  in  8  byte returned by RAM, valid one cycle after its address.
- ram_dout  out  8  write byte.
- ram_addr  out  32  byte address.
- ram_wr  out  1  1 = write.
- io_buffer_full  in  1  UART tx buffer full.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  32  fetch address.
- flush  in  1  branch redirect; aborts an IF transaction.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word, little-endian.
- mem_req  in  1  load/store request; held until mem_done.
- mem_we  in  1  1 = store.
- mem_addr  in  32  data address.
- mem_len  in  3  bytes: 1, 2 or 4.
- mem_signed  in  1  sign-extend a load.
- mem_wdata  in  32  store data, byte 0 sent first.
- mem_done  out  1  one-cycle pulse.
- mem_rdata  out  32  load result.
- if_busy, mem_busy  out  1  owner of the port is IF / MEM.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All outputs 0.
  - Counters cleared.
  - Applies even mid-transaction, with no write completion.
- rdy=0:
  - No register updates.
  - ram_wr forced 0 combinationally.
  - ram_addr holds.
- States: IDLE, RD, WR, DONE.
- IDLE, edge with a request:
  - mem_req has priority over if_req.
  - if_req is ignored on an edge where flush=1.
  - Latch owner, base, len and wdata.
  - cnt<=0.
  - Next state RD or WR (IF is always RD with len 4).
  - mem_len other than 1 or 2 is treated as 4.
- RD:
  - ram_addr = base+cnt (32-bit wrap), ram_wr=0.
  - Each edge captures ram_din into byte cnt-1 (when cnt≥1) and increments cnt.
  - After capturing byte len-1, go to DONE.
  - Latency: acceptance edge to the done cycle is len+1 edges.
- WR:
  - ram_addr = base+cnt, ram_dout = byte cnt, ram_wr=1.
  - cnt increments each edge; after byte len-1 is sent, go to DONE (len edges).
  - IO stall: if base[17:16]==IO_HI and io_buffer_full=1, then ram_wr=0 and cnt holds.
- DONE:
  - done pulse of the owner is high for exactly this cycle.
  - mem_rdata / if_data are valid this cycle and held until the next transaction.
  - No request is accepted on the edge ending DONE.
  - Next state IDLE.
- Load extension:
  - len1 signed: bits[31:8] = byte0[7].
  - len2 signed: bits[31:16] = bit15.
  - Unsigned loads are zero-extended.
- Flush with owner=IF in RD: next edge goes to IDLE; no if_done; no data update. Flush never affects a MEM transaction.
- Busy flags: if_busy / mem_busy are high in RD, WR and DONE for the owner.
- IDLE outputs: ram_wr=0, ram_addr=0.

Test Plan:
- Fetch 0x100, RAM bytes 13,05,00,00 → ram_addr 0x100..0x103 on consecutive cycles; if_done 5 edges after acceptance; if_data=0x00000513.
- if_req and mem_req (LW 0x200) raised in the same cycle → MEM served first; IF accepted 1 cycle after mem_done (DONE bubble).
- LB 0x80 signed → 0xFFFFFF80. LHU with bytes 01,80 → 0x00008001. LH with the same bytes → 0xFFFF8001.
- SB 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → ram_wr=0 for those cycles, then a single ram_wr=1 with ram_dout=0x41; SW to 0x1000 of 0xDEADBEEF → bytes EF,BE,AD,DE.
- Flush during the 2nd byte of a fetch → no if_done; a pending mem_req is accepted the next cycle. rdy=0 for 4 cycles mid-LW → addr/cnt frozen, result unchanged.
- rst=0 mid-SW → outputs 0 immediately (async); after release, IDLE with no further ram_wr.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Byte-wide RAM/IO port plus the IF and MEM requester handshakes of the arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface ram_port_arbiter_if;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic        io_buffer_full;

   logic        if_req;
   logic [31:0] if_addr;
   logic        flush;
   logic        if_done;
   logic [31:0] if_data;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [2:0]  mem_len;
   logic        mem_signed;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;

   logic        if_busy;
   logic        mem_busy;

   modport slave (
      input  ram_din, io_buffer_full,
      input  if_req, if_addr, flush,
      input  mem_req, mem_we, mem_addr, mem_len, mem_signed, mem_wdata,
      output ram_dout, ram_addr, ram_wr,
      output if_done, if_data, mem_done, mem_rdata, if_busy, mem_busy
   );

   modport master (
      output ram_din, io_buffer_full,
      output if_req, if_addr, flush,
      output mem_req, mem_we, mem_addr, mem_len, mem_signed, mem_wdata,
      input  ram_dout, ram_addr, ram_wr,
      input  if_done, if_data, mem_done, mem_rdata, if_busy, mem_busy
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the byte-wide RAM/IO port between fetch and load/store; reads take len+1 edges, writes len.
// Requests are held by the requester until done; rdy=0 freezes everything, a full UART buffer stalls IO writes.
module ram_port_arbiter #(
   parameter logic [1:0] IO_HI = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;
   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic [31:0] base_q, base_d;
   logic [2:0]  len_q, len_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] wdata_q, wdata_d;
   logic        sgn_q, sgn_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic        io_stall;
   logic [31:0] xfer_addr;
   logic [7:0]  wr_byte;

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] len,
                                          input logic sgn);
      logic [31:0] r;
      case (len)
         3'd1:    r = {{24{sgn & raw[7]}}, raw[7:0]};
         3'd2:    r = {{16{sgn & raw[15]}}, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   assign io_stall  = (base_q[17:16] == IO_HI) && bus.io_buffer_full;
   assign xfer_addr = base_q + {29'd0, cnt_q};

   always_comb begin
      case (cnt_q[1:0])
         2'd0:    wr_byte = wdata_q[7:0];
         2'd1:    wr_byte = wdata_q[15:8];
         2'd2:    wr_byte = wdata_q[23:16];
         default: wr_byte = wdata_q[31:24];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      base_d      = base_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      wdata_d     = wdata_q;
      sgn_d       = sgn_q;
      rbuf_d      = rbuf_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if (rdy) begin
         case (state_q)
            S_IDLE: begin
               if (bus.mem_req) begin
                  owner_d = OWN_MEM;
                  base_d  = bus.mem_addr;
                  len_d   = (bus.mem_len == 3'd1) ? 3'd1 :
                            (bus.mem_len == 3'd2) ? 3'd2 : 3'd4;
                  wdata_d = bus.mem_wdata;
                  sgn_d   = bus.mem_signed;
                  cnt_d   = 3'd0;
                  rbuf_d  = 32'd0;
                  state_d = bus.mem_we ? S_WR : S_RD;
               end else if (bus.if_req && !bus.flush) begin
                  owner_d = OWN_IF;
                  base_d  = bus.if_addr;
                  len_d   = 3'd4;
                  wdata_d = 32'd0;
                  sgn_d   = 1'b0;
                  cnt_d   = 3'd0;
                  rbuf_d  = 32'd0;
                  state_d = S_RD;
               end
            end
            S_RD: begin
               if (owner_q == OWN_IF && bus.flush) begin
                  state_d = S_IDLE;
               end else begin
                  // ram_din lags the address by a cycle, so it belongs to byte cnt-1
                  case (cnt_q)
                     3'd1:    rbuf_d[7:0]   = bus.ram_din;
                     3'd2:    rbuf_d[15:8]  = bus.ram_din;
                     3'd3:    rbuf_d[23:16] = bus.ram_din;
                     3'd4:    rbuf_d[31:24] = bus.ram_din;
                     default: ;
                  endcase
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == len_q) begin
                     state_d = S_DONE;
                     if (owner_q == OWN_IF) begin
                        if_data_d = rbuf_d;
                     end else begin
                        mem_rdata_d = extend(rbuf_d, len_q, sgn_q);
                     end
                  end
               end
            end
            S_WR: begin
               if (!io_stall) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == len_q - 3'd1) begin
                     state_d = S_DONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IF;
         base_q      <= 32'd0;
         len_q       <= 3'd0;
         cnt_q       <= 3'd0;
         wdata_q     <= 32'd0;
         sgn_q       <= 1'b0;
         rbuf_q      <= 32'd0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         sgn_q       <= sgn_d;
         rbuf_q      <= rbuf_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.ram_addr  = (state_q == S_RD || state_q == S_WR) ? xfer_addr : 32'd0;
   assign bus.ram_dout  = (state_q == S_WR) ? wr_byte : 8'd0;
   assign bus.ram_wr    = rdy && (state_q == S_WR) && !io_stall;
   assign bus.if_done   = (state_q == S_DONE) && (owner_q == OWN_IF);
   assign bus.mem_done  = (state_q == S_DONE) && (owner_q == OWN_MEM);
   assign bus.if_busy   = (state_q != S_IDLE) && (owner_q == OWN_IF);
   assign bus.mem_busy  = (state_q != S_IDLE) && (owner_q == OWN_MEM);
   assign bus.if_data   = if_data_q;
   assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter: byte RAM model, expected fetch/load/write queues.
module tb_ram_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic rdy;

   always #5 clk = ~clk;

   ram_port_arbiter_if bus();

   ram_port_arbiter #(.IO_HI(2'b11)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int mem_done_cyc = 0;
   int if_done_cyc  = 0;
   bit wr_mon_en = 1'b1;

   logic [7:0]  ram_m [logic [31:0]];
   logic [31:0] exp_if  [$];
   logic [32:0] exp_mem [$];
   logic [39:0] exp_wr  [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      return ram_m.exists(a) ? ram_m[a] : 8'h00;
   endfunction

   function automatic logic [31:0] load_exp(input logic [31:0] a, input logic [2:0] len,
                                            input logic sgn);
      logic [7:0] b0, b1, b2, b3;
      b0 = rd_byte(a); b1 = rd_byte(a + 1); b2 = rd_byte(a + 2); b3 = rd_byte(a + 3);
      if (len == 3'd1) return sgn ? {{24{b0[7]}}, b0} : {24'd0, b0};
      if (len == 3'd2) return sgn ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
      return {b3, b2, b1, b0};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // RAM answers one cycle after the address and freezes with the rest of the chip
   always @(posedge clk) begin
      if (rdy) begin
         if (bus.ram_wr) ram_m[bus.ram_addr] = bus.ram_dout;
         bus.ram_din <= rd_byte(bus.ram_addr);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (bus.if_done) begin
            if_done_cyc = cyc;
            chk("if_done_expected", exp_if.size() != 0, 1);
            if (exp_if.size() != 0) chk("if_data", bus.if_data, exp_if.pop_front());
         end
         if (bus.mem_done) begin
            logic [32:0] e;
            mem_done_cyc = cyc;
            chk("mem_done_expected", exp_mem.size() != 0, 1);
            if (exp_mem.size() != 0) begin
               e = exp_mem.pop_front();
               if (e[32]) chk("mem_rdata", bus.mem_rdata, e[31:0]);
            end
         end
         if (wr_mon_en && bus.ram_wr) begin
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) chk("wr_addr_dat", {bus.ram_addr, bus.ram_dout}, exp_wr.pop_front());
         end
      end
   end

   task automatic drive_mem(input logic we, input logic [31:0] addr, input logic [2:0] len,
                            input logic sgn, input logic [31:0] wd);
      bus.mem_we     = we;
      bus.mem_addr   = addr;
      bus.mem_len    = len;
      bus.mem_signed = sgn;
      bus.mem_wdata  = wd;
      bus.mem_req    = 1'b1;
   endtask

   task automatic push_mem(input logic we, input logic [31:0] addr, input logic [2:0] len,
                           input logic sgn, input logic [31:0] wd);
      logic [31:0] w;
      w = wd;
      if (we) begin
         for (int i = 0; i < int'(len); i++) begin
            exp_wr.push_back({addr + i, w[7:0]});
            w = w >> 8;
         end
      end
      exp_mem.push_back({!we, we ? 32'd0 : load_exp(addr, len, sgn)});
   endtask

   task automatic finish_mem();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_done && n < 60);
      chk("mem_done_seen", bus.mem_done, 1);
      @(posedge clk); #1;
      bus.mem_req = 1'b0;
   endtask

   task automatic mem_xact(input logic we, input logic [31:0] addr, input logic [2:0] len,
                           input logic sgn, input logic [31:0] wd);
      push_mem(we, addr, len, sgn, wd);
      drive_mem(we, addr, len, sgn, wd);
      finish_mem();
   endtask

   task automatic if_xact(input logic [31:0] addr, input bit chk_lat);
      int n = 0;
      int acc;
      exp_if.push_back(load_exp(addr, 3'd4, 1'b0));
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
      if (chk_lat) begin
         @(posedge clk); #1;
         acc = cyc;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("if_addr_seq", bus.ram_addr, addr + i);
         end
      end
      do begin
         @(negedge clk);
         n++;
      end while (!bus.if_done && n < 60);
      chk("if_done_seen", bus.if_done, 1);
      if (chk_lat) chk("if_latency", cyc - acc, 5);
      @(posedge clk); #1;
      bus.if_req = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      bus.io_buffer_full = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.flush = 1'b0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'd0;
      bus.mem_len = 3'd0; bus.mem_signed = 1'b0; bus.mem_wdata = 32'd0;
      ram_m[32'h100] = 8'h13; ram_m[32'h101] = 8'h05; ram_m[32'h102] = 8'h00; ram_m[32'h103] = 8'h00;
      ram_m[32'h200] = 8'h78; ram_m[32'h201] = 8'h56; ram_m[32'h202] = 8'h34; ram_m[32'h203] = 8'h12;
      ram_m[32'h080] = 8'h80;
      ram_m[32'h300] = 8'h01; ram_m[32'h301] = 8'h80;

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_ram_wr",    bus.ram_wr, 0);
      chk("rst_ram_addr",  bus.ram_addr, 0);
      chk("rst_busy",      {bus.if_busy, bus.mem_busy}, 0);
      chk("rst_done",      {bus.if_done, bus.mem_done}, 0);
      chk("rst_data",      {bus.if_data, bus.mem_rdata}, 0);
      @(posedge clk); #1;

      // plain fetch: addresses, latency, little-endian assembly
      if_xact(32'h100, 1'b1);

      // simultaneous requests: MEM first, IF accepted after the DONE bubble
      fork
         mem_xact(1'b0, 32'h200, 3'd4, 1'b0, 32'd0);
         if_xact(32'h100, 1'b0);
      join
      chk("arb_if_after_mem", if_done_cyc - mem_done_cyc, 7);

      // load extension
      mem_xact(1'b0, 32'h080, 3'd1, 1'b1, 32'd0);
      mem_xact(1'b0, 32'h080, 3'd1, 1'b0, 32'd0);
      mem_xact(1'b0, 32'h300, 3'd2, 1'b0, 32'd0);
      mem_xact(1'b0, 32'h300, 3'd2, 1'b1, 32'd0);

      // UART write stalled by a full buffer for 3 cycles
      push_mem(1'b1, 32'h30000, 3'd1, 1'b0, 32'h41);
      bus.io_buffer_full = 1'b1;
      drive_mem(1'b1, 32'h30000, 3'd1, 1'b0, 32'h41);
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("io_stall_wr", bus.ram_wr, 0);
         @(posedge clk);
      end
      #1 bus.io_buffer_full = 1'b0;
      finish_mem();

      // word store then read back
      mem_xact(1'b1, 32'h1000, 3'd4, 1'b0, 32'hDEADBEEF);
      mem_xact(1'b0, 32'h1000, 3'd4, 1'b0, 32'd0);

      // flush during the 2nd fetch byte with a load waiting
      push_mem(1'b0, 32'h200, 3'd4, 1'b0, 32'd0);
      bus.if_addr = 32'h100;
      bus.if_req  = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      chk("flush_2nd_byte_addr", bus.ram_addr, 32'h101);
      bus.flush = 1'b1;
      drive_mem(1'b0, 32'h200, 3'd4, 1'b0, 32'd0);
      @(posedge clk); #1;
      bus.flush  = 1'b0;
      bus.if_req = 1'b0;
      @(negedge clk);
      chk("flush_idle", {bus.if_busy, bus.mem_busy}, 0);
      chk("flush_if_data", bus.if_data, 32'h00000513);
      @(posedge clk);
      @(negedge clk);
      chk("flush_mem_accept", bus.mem_busy, 1);
      finish_mem();

      // rdy low for 4 cycles in the middle of a word load
      push_mem(1'b0, 32'h1000, 3'd4, 1'b0, 32'd0);
      drive_mem(1'b0, 32'h1000, 3'd4, 1'b0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rdy_addr_hold", bus.ram_addr, 32'h1002);
         chk("rdy_busy_hold", bus.mem_busy, 1);
         @(posedge clk);
      end
      #1 rdy = 1'b1;
      finish_mem();

      // asynchronous reset in the middle of a store
      wr_mon_en = 1'b0;
      drive_mem(1'b1, 32'h2000, 3'd4, 1'b0, 32'h11223344);
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("arst_ram_wr",   bus.ram_wr, 0);
      chk("arst_ram_addr", bus.ram_addr, 0);
      chk("arst_ram_dout", bus.ram_dout, 0);
      chk("arst_busy",     {bus.if_busy, bus.mem_busy}, 0);
      chk("arst_data",     {bus.if_data, bus.mem_rdata}, 0);
      bus.mem_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_no_wr", {bus.ram_wr, bus.mem_busy, bus.mem_done}, 0);
      end
      wr_mon_en = 1'b1;

      chk("exp_if_drained",  exp_if.size(), 0);
      chk("exp_mem_drained", exp_mem.size(), 0);
      chk("exp_wr_drained",  exp_wr.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
